gcd_arbiter: RTL and testbench

Round-robin scheduler that shares one gcd_top core between NUM_REQ independent requesters. It grants one request at a time, captures that request's operands, and sequences the core's start/done handshake. It returns the result tagged with the requester ID. Operand-zero cases are resolved locally without using the core, and a watchdog aborts a core that never raises done. The block sits between client logic and the single gcd_top instance.

---
 rtl/gcd_arbiter.sv | 158 +++++++++++++++
 tb/tb_gcd_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one gcd_top core between NUM_REQ requesters.
// Zero operands are answered locally; a watchdog aborts a core that never finishes.
module gcd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 10,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ID_W           = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       resp_valid,
    output logic [ID_W-1:0]            resp_id,
    output logic [WIDTH-1:0]           resp_data,
    output logic                       resp_err,
    output logic                       core_start,
    output logic [WIDTH-1:0]           core_a,
    output logic [WIDTH-1:0]           core_b,
    input  logic [WIDTH-1:0]           core_result,
    input  logic                       core_done,
    output logic                       busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    state_t            state_r;
    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   id_r;
    logic [WIDTH-1:0]  res_r;
    logic              err_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [ID_W-1:0]   cand_s [NUM_REQ];
    logic [WIDTH-1:0]  a_arr_s [NUM_REQ];
    logic [WIDTH-1:0]  b_arr_s [NUM_REQ];
    logic              grant_found_s;
    logic [ID_W-1:0]   grant_id_s;
    logic [WIDTH-1:0]  grant_a_s;
    logic [WIDTH-1:0]  grant_b_s;
    logic [ID_W-1:0]   next_ptr_s;

    // Round-robin search upward from the pointer, plus operand unpacking
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = {ID_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s[k]  = ID_W'((int'(ptr_r) + k) % NUM_REQ);
            a_arr_s[k] = req_a[k*WIDTH +: WIDTH];
            b_arr_s[k] = req_b[k*WIDTH +: WIDTH];
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found_s && req[cand_s[k]]) begin
                grant_found_s = 1'b1;
                grant_id_s    = cand_s[k];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        grant_a_s = a_arr_s[grant_id_s];
        grant_b_s = b_arr_s[grant_id_s];
        if (id_r == ID_W'(NUM_REQ - 1)) begin
            next_ptr_s = {ID_W{1'b0}};
        end else begin
            next_ptr_s = id_r + ID_W'(1);
        end
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {ID_W{1'b0}};
            id_r       <= {ID_W{1'b0}};
            res_r      <= {WIDTH{1'b0}};
            err_r      <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            ack        <= {NUM_REQ{1'b0}};
            resp_valid <= 1'b0;
            resp_id    <= {ID_W{1'b0}};
            resp_data  <= {WIDTH{1'b0}};
            resp_err   <= 1'b0;
            core_start <= 1'b0;
            core_a     <= {WIDTH{1'b0}};
            core_b     <= {WIDTH{1'b0}};
            busy       <= 1'b0;
        end else begin
            ack        <= {NUM_REQ{1'b0}};
            resp_valid <= 1'b0;
            core_start <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        id_r     <= grant_id_s;
                        core_a   <= grant_a_s;
                        core_b   <= grant_b_s;
                        ack      <= NUM_REQ'(1) << grant_id_s;
                        resp_err <= 1'b0;
                        busy     <= 1'b1;
                        // gcd(0,x)=x and gcd(x,0)=x, so the nonzero operand (or 0) is the answer
                        if ((grant_a_s == {WIDTH{1'b0}}) || (grant_b_s == {WIDTH{1'b0}})) begin
                            res_r   <= (grant_a_s == {WIDTH{1'b0}}) ? grant_b_s : grant_a_s;
                            err_r   <= 1'b0;
                            state_r <= ST_DELIVER;
                        end else begin
                            core_start <= 1'b1;
                            state_r    <= ST_LAUNCH;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done is checked first so it wins over a simultaneous timeout
                    if (core_done) begin
                        res_r   <= core_result;
                        err_r   <= 1'b0;
                        state_r <= ST_DELIVER;
                    end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        res_r   <= {WIDTH{1'b0}};
                        err_r   <= 1'b1;
                        state_r <= ST_DELIVER;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DELIVER: begin
                    resp_valid <= 1'b1;
                    resp_id    <= id_r;
                    resp_data  <= res_r;
                    resp_err   <= err_r;
                    ptr_r      <= next_ptr_s;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural gcd core (fixed delay or hung).
module tb_gcd_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 10;
    localparam int TMO     = 16;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       ack;
    logic                     resp_valid;
    logic [ID_W-1:0]          resp_id;
    logic [WIDTH-1:0]         resp_data;
    logic                     resp_err;
    logic                     core_start;
    logic [WIDTH-1:0]         core_a;
    logic [WIDTH-1:0]         core_b;
    logic [WIDTH-1:0]         core_result;
    logic                     core_done;
    logic                     busy;

    int checks_total  = 0;
    int checks_passed = 0;
    int start_count   = 0;
    int core_delay    = 6;
    bit core_hang     = 1'b0;
    int exp_id   [4];
    int exp_data [4];
    int exp_err  [4];

    gcd_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .ack(ack),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
        .core_start(core_start), .core_a(core_a), .core_b(core_b),
        .core_result(core_result), .core_done(core_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int gcd_f(input int a, input int b);
        int x = a;
        int y = b;
        while (y != 0) begin
            int t = y;
            y = x % y;
            x = t;
        end
        return x;
    endfunction

    // Core model: done is sampled after core_delay low WAIT cycles, unless hung
    initial begin
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                start_count++;
                if (!core_hang) begin
                    repeat (core_delay + 1) @(negedge clk);
                    core_result = WIDTH'(gcd_f(int'(core_a), int'(core_b)));
                    core_done   = 1'b1;
                    @(negedge clk);
                    core_done   = 1'b0;
                end
            end
        end
    end

    task automatic set_req(input int id, input int a, input int b);
        req_a[id*WIDTH +: WIDTH] = a[WIDTH-1:0];
        req_b[id*WIDTH +: WIDTH] = b[WIDTH-1:0];
        req[id] = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ctrl"}, {ack, resp_valid, resp_err, core_start, busy}, 32'd0);
        check_eq({tag, "_resp"}, {resp_id, resp_data}, 32'd0);
        check_eq({tag, "_core"}, {core_a, core_b}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
    endtask

    // Collect n responses in the order given by exp_*; called on the negedge where req was raised
    task automatic run_batch(input int n, input int exp_lat, input int exp_starts);
        int k = 0;
        int cyc = 0;
        int first_lat = -1;
        int s0 = start_count;
        while (k < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (ack != '0) begin
                check_eq("ack_onehot", $countones(ack), 32'd1);
                check_eq("err_clr", resp_err, 32'd0);
                req = req & ~ack;
            end
            if (resp_valid) begin
                if (k == 0) first_lat = cyc;
                check_eq("resp_id", resp_id, exp_id[k]);
                check_eq("resp_data", resp_data, exp_data[k]);
                check_eq("resp_err", resp_err, exp_err[k]);
                k++;
            end
        end
        check_eq("resp_count", k, n);
        if (exp_lat > 0) check_eq("latency", first_lat, exp_lat);
        check_eq("core_starts", start_count - s0, exp_starts);
    endtask

    initial begin
        int cyc;
        int stray;
        rst   = 1'b1;
        req   = '0;
        req_a = '0;
        req_b = '0;
        @(negedge clk);
        do_reset();

        // Single core job, D=6 -> latency 4+6
        set_req(0, 15, 5);
        exp_id[0] = 0; exp_data[0] = 5; exp_err[0] = 0;
        run_batch(1, 10, 1);

        // All four at once from pointer 0
        do_reset();
        set_req(0, 30, 10); set_req(1, 18, 24); set_req(2, 21, 14); set_req(3, 9, 6);
        exp_id[0] = 0; exp_data[0] = 10; exp_err[0] = 0;
        exp_id[1] = 1; exp_data[1] = 6;  exp_err[1] = 0;
        exp_id[2] = 2; exp_data[2] = 7;  exp_err[2] = 0;
        exp_id[3] = 3; exp_data[3] = 3;  exp_err[3] = 0;
        run_batch(4, 0, 4);

        // Fairness: after ID1 the pointer is 2, so ID3 beats ID0
        set_req(1, 18, 24);
        exp_id[0] = 1; exp_data[0] = 6; exp_err[0] = 0;
        run_batch(1, 0, 1);
        set_req(0, 15, 5); set_req(3, 9, 6);
        exp_id[0] = 3; exp_data[0] = 3; exp_err[0] = 0;
        exp_id[1] = 0; exp_data[1] = 5; exp_err[1] = 0;
        run_batch(2, 0, 2);

        // Zero bypass
        set_req(2, 0, 24);
        exp_id[0] = 2; exp_data[0] = 24; exp_err[0] = 0;
        run_batch(1, 2, 0);
        set_req(2, 0, 0);
        exp_id[0] = 2; exp_data[0] = 0; exp_err[0] = 0;
        run_batch(1, 2, 0);

        // Timeout with a hung core, then a normal job
        core_hang = 1'b1;
        set_req(1, 12, 8);
        exp_id[0] = 1; exp_data[0] = 0; exp_err[0] = 1;
        run_batch(1, 0, 1);
        core_hang = 1'b0;
        set_req(1, 12, 8);
        exp_id[0] = 1; exp_data[0] = 4; exp_err[0] = 0;
        run_batch(1, 0, 1);

        // Reset while in WAIT abandons the job silently
        core_hang = 1'b1;
        set_req(0, 15, 5);
        cyc = 0;
        while (!core_start && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("start_seen", core_start, 32'd1);
        req = '0;
        repeat (3) @(negedge clk);
        check_eq("busy_wait", busy, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        core_hang = 1'b0;
        stray = 0;
        repeat (25) begin
            @(negedge clk);
            if (resp_valid) stray++;
        end
        check_eq("no_stray_resp", stray, 32'd0);
        set_req(0, 18, 24); set_req(3, 9, 6);
        exp_id[0] = 0; exp_data[0] = 6; exp_err[0] = 0;
        exp_id[1] = 3; exp_data[1] = 3; exp_err[1] = 0;
        run_batch(2, 0, 2);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
